// File: rtl/pdm_pkg.sv
// pdm_pkg: shared types and helpers for the multi-channel PDM modulator.
//   pdm_state_t      : modulator run state (idle / run)
//   pdm_maxv(width)  : largest signed value representable in 'width' bits
//   pdm_minv(width)  : smallest signed value representable in 'width' bits
package pdm_pkg;

  typedef enum logic {
    PDM_IDLE = 1'b0,
    PDM_RUN  = 1'b1
  } pdm_state_t;

  function automatic int pdm_maxv(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int pdm_minv(input int width);
    return -(1 << (width - 1));
  endfunction

endpackage

// File: rtl/pdm_chan_core.sv
// pdm_chan_core: one channel of the PDM noise-shaping loop.
//   clk      : clock, posedge
//   rst_n    : synchronous reset, active-low
//   clr      : clear integrators and output bit (leaving RUN)
//   step     : advance the loop by one PDM bit
//   sample   : signed input sample held for this step
//   pdm_bit  : registered PDM output bit
// Build option PDM_SECOND_ORDER_EN: two cascaded WIDTH+4 bit integrators;
// otherwise a single WIDTH+2 bit first-order accumulator.
module pdm_chan_core
  import pdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    step,
  input  logic signed [WIDTH-1:0] sample,
  output logic                    pdm_bit
);

`ifdef PDM_SECOND_ORDER_EN
  localparam int AW = WIDTH + 4;
`else
  localparam int AW = WIDTH + 2;
`endif

  localparam logic signed [AW-1:0] MAXV_E = AW'(pdm_maxv(WIDTH));
  localparam logic signed [AW-1:0] MINV_E = AW'(pdm_minv(WIDTH));

  logic signed [AW-1:0] x_ext;
  logic signed [AW-1:0] fb;
  logic                 bit_q, bit_d;

  assign x_ext   = {{(AW - WIDTH){sample[WIDTH-1]}}, sample};
  // Feedback is the full-scale value the previous output bit represents.
  assign fb      = bit_q ? MAXV_E : MINV_E;
  assign pdm_bit = bit_q;

`ifdef PDM_SECOND_ORDER_EN
  logic signed [AW-1:0] i1_q, i1_d;
  logic signed [AW-1:0] i2_q, i2_d;

  always_comb begin
    i1_d  = i1_q;
    i2_d  = i2_q;
    bit_d = bit_q;
    if (clr) begin
      i1_d  = '0;
      i2_d  = '0;
      bit_d = 1'b0;
    end else if (step) begin
      i1_d  = i1_q + x_ext - fb;
      i2_d  = i2_q + i1_d - fb;
      bit_d = ~i2_d[AW-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i1_q  <= '0;
      i2_q  <= '0;
      bit_q <= 1'b0;
    end else begin
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      bit_q <= bit_d;
    end
  end
`else
  logic signed [AW-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    bit_d = bit_q;
    if (clr) begin
      acc_d = '0;
      bit_d = 1'b0;
    end else if (step) begin
      acc_d = acc_q + x_ext - fb;
      bit_d = ~acc_d[AW-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      bit_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      bit_q <= bit_d;
    end
  end
`endif

endmodule

// File: rtl/pdm_multi_mod.sv
// pdm_multi_mod: multi-channel first-order (optionally second-order) PDM modulator.
//   clk_in           : clock, posedge
//   rst_n_in         : synchronous reset, active-low
//   enable_in        : 1 = run, 0 = return to idle
//   tick_in          : PDM bit-rate strobe
//   s_valid_in       : frame valid
//   s_data_in        : frame, channel c at [c*WIDTH +: WIDTH], signed
//   s_ready_out      : pending buffer can accept
//   pdm_out          : registered PDM bit per channel
//   underrun_out     : one-cycle pulse on a RUN tick with no pending frame
//   underrun_cnt_out : saturating underrun count
// Build option PDM_SECOND_ORDER_EN selects the second-order loop in each channel.
//
// state    | meaning
// PDM_IDLE | outputs held at 0, waits for enable + pending frame + tick
// PDM_RUN  | each tick steps all channels and promotes pending -> active
module pdm_multi_mod
  import pdm_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 8,
  parameter int UCNT_W = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      enable_in,
  input  logic                      tick_in,
  input  logic                      s_valid_in,
  input  logic [NUM_CH*WIDTH-1:0]   s_data_in,
  output logic                      s_ready_out,
  output logic [NUM_CH-1:0]         pdm_out,
  output logic                      underrun_out,
  output logic [UCNT_W-1:0]         underrun_cnt_out
);

  pdm_state_t                state_q, state_d;
  logic                      pending_full_q, pending_full_d;
  logic [NUM_CH*WIDTH-1:0]   pending_q, pending_d;
  logic [NUM_CH*WIDTH-1:0]   active_q, active_d;
  logic                      underrun_q, underrun_d;
  logic [UCNT_W-1:0]         ucnt_q, ucnt_d;

  logic accept;
  logic promote;
  logic step;
  logic clr;

  assign accept           = s_valid_in && !pending_full_q;
  assign s_ready_out      = !pending_full_q;
  assign underrun_out     = underrun_q;
  assign underrun_cnt_out = ucnt_q;

  always_comb begin
    state_d        = state_q;
    pending_full_d = pending_full_q;
    pending_d      = pending_q;
    active_d       = active_q;
    underrun_d     = 1'b0;
    ucnt_d         = ucnt_q;
    promote        = 1'b0;
    step           = 1'b0;
    clr            = 1'b0;

    case (state_q)
      PDM_IDLE: begin
        // The entry tick only promotes; modulation starts on the next tick.
        if (enable_in && tick_in && pending_full_q) begin
          promote = 1'b1;
          state_d = PDM_RUN;
        end
      end
      PDM_RUN: begin
        if (!enable_in) begin
          clr      = 1'b1;
          active_d = '0;
          state_d  = PDM_IDLE;
        end else if (tick_in) begin
          step = 1'b1;
          if (pending_full_q) begin
            promote = 1'b1;
          end else begin
            underrun_d = 1'b1;
            if (ucnt_q != '1) ucnt_d = ucnt_q + UCNT_W'(1);
          end
        end
      end
      default: state_d = PDM_IDLE;
    endcase

    if (promote) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end
    // Accept is only possible with pending empty, so it never overwrites
    // a frame that has not been promoted.
    if (accept) begin
      pending_d      = s_data_in;
      pending_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q        <= PDM_IDLE;
      pending_full_q <= 1'b0;
      pending_q      <= '0;
      active_q       <= '0;
      underrun_q     <= 1'b0;
      ucnt_q         <= '0;
    end else begin
      state_q        <= state_d;
      pending_full_q <= pending_full_d;
      pending_q      <= pending_d;
      active_q       <= active_d;
      underrun_q     <= underrun_d;
      ucnt_q         <= ucnt_d;
    end
  end

  // Modulation uses active_q, i.e. the sample held before this tick's promotion.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pdm_chan_core #(.WIDTH(WIDTH)) u_core (
      .clk     (clk_in),
      .rst_n   (rst_n_in),
      .clr     (clr),
      .step    (step),
      .sample  (active_q[c*WIDTH +: WIDTH]),
      .pdm_bit (pdm_out[c])
    );
  end

endmodule

// File: tb/tb_pdm_multi_mod.sv
module tb_pdm_multi_mod;
  localparam int NUM_CH = 2;
  localparam int WIDTH  = 8;
  localparam int UCNT_W = 4;
  localparam int MAXV   = 127;
  localparam int MINV   = -128;
  localparam int CMAX   = 15;

  logic        clk = 1'b0;
  logic        rst_n, en, tick, valid;
  logic [15:0] data;
  logic        ready, ur;
  logic [1:0]  pdm;
  logic [3:0]  cnt;

  int checks   = 0;
  int failures = 0;

  pdm_multi_mod #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .UCNT_W(UCNT_W)) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .enable_in        (en),
    .tick_in          (tick),
    .s_valid_in       (valid),
    .s_data_in        (data),
    .s_ready_out      (ready),
    .pdm_out          (pdm),
    .underrun_out     (ur),
    .underrun_cnt_out (cnt)
  );

  always #5 clk = ~clk;

  // Reference model: frame pipeline as plain variables, loop as integer arithmetic.
  logic       m_run, m_pfull, m_ur;
  int         m_pend [2];
  int         m_act  [2];
  int         m_i1   [2];
  int         m_i2   [2];
  logic       m_bit  [2];
  int         m_cnt;
  logic [7:0] exp_q [$];

  function automatic int sx8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  task automatic model_cycle(input logic r, input logic e, input logic t, input logic v,
                             input logic [15:0] d);
    logic took;
    int   fb;
    if (!r) begin
      m_run = 0; m_pfull = 0; m_ur = 0; m_cnt = 0;
      for (int c = 0; c < 2; c++) begin
        m_pend[c] = 0; m_act[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_bit[c] = 0;
      end
    end else begin
      took = v && !m_pfull;
      m_ur = 0;
      if (m_run && !e) begin
        m_run = 0;
        for (int c = 0; c < 2; c++) begin
          m_act[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_bit[c] = 0;
        end
      end else if (m_run) begin
        if (t) begin
          for (int c = 0; c < 2; c++) begin
            fb = m_bit[c] ? MAXV : MINV;
            m_i1[c] = m_i1[c] + m_act[c] - fb;
`ifdef PDM_SECOND_ORDER_EN
            m_i2[c] = m_i2[c] + m_i1[c] - fb;
            m_bit[c] = (m_i2[c] >= 0);
`else
            m_bit[c] = (m_i1[c] >= 0);
`endif
          end
          if (m_pfull) begin
            m_act[0] = m_pend[0]; m_act[1] = m_pend[1]; m_pfull = 0;
          end else begin
            m_ur = 1;
            if (m_cnt < CMAX) m_cnt++;
          end
        end
      end else if (t && e && m_pfull) begin
        m_act[0] = m_pend[0]; m_act[1] = m_pend[1]; m_pfull = 0; m_run = 1;
      end
      if (took) begin
        m_pend[0] = sx8(d[7:0]); m_pend[1] = sx8(d[15:8]); m_pfull = 1;
      end
    end
    exp_q.push_back({!m_pfull, 4'(m_cnt), m_ur, m_bit[1], m_bit[0]});
  endtask

  task automatic step(input logic r, input logic e, input logic t, input logic v,
                      input logic [15:0] d);
    rst_n = r; en = e; tick = t; valid = v; data = d;
    model_cycle(r, e, t, v, d);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=[%0d..%0d]", name, act, lo, hi);
    end
  endtask

  // Scoreboard monitor: one expected output vector per clock.
  always @(negedge clk) begin
    logic [7:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {ready, cnt, ur, pdm};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t actual{rdy,cnt,ur,pdm}=%b required=%b", $time, a, e);
      end
    end
  end

  task automatic density(input logic [7:0] x, input int n, output int ones);
    ones = 0;
    step(0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 1, {8'h00, x});
    step(1, 1, 1, 0, 16'h0);
    for (int i = 0; i < n; i++) begin
      step(1, 1, 1, 1, {8'h00, x});
      ones += int'(pdm[0]);
    end
  endtask

  initial begin
    int ones0, ones1, urs;
    rst_n = 0; en = 0; tick = 0; valid = 0; data = '0;

    // Reset state
    step(0, 1, 1, 1, 16'hFFFF);
    check("reset_ready", int'(ready), 1, 1);
    check("reset_pdm", int'(pdm), 0, 0);
    check("reset_cnt", int'(cnt), 0, 0);

    // Full scale: ch0 = MAXV, ch1 = MINV
    step(1, 0, 0, 1, 16'h807F);
    step(1, 1, 1, 0, 16'h0);
    ones0 = 0; ones1 = 0;
    for (int i = 0; i < 64; i++) begin
      step(1, 1, 1, 1, 16'h807F);
      if (i >= 2) begin
        ones0 += int'(pdm[0]);
        ones1 += int'(pdm[1]);
      end
    end
    check("fullscale_ch0_ones", ones0, 62, 62);
    check("fullscale_ch1_ones", ones1, 0, 0);

    // Reset mid-RUN
    step(0, 1, 1, 1, 16'h1234);
    check("midrun_reset_pdm", int'(pdm), 0, 0);
    check("midrun_reset_ready", int'(ready), 1, 1);
    check("midrun_reset_cnt", int'(cnt), 0, 0);

    // Densities
    density(8'h00, 256, ones0);
    check("density_zero", ones0, 127, 129);
    density(8'h40, 256, ones0);
    check("density_64", ones0, 190, 194);

    // Underrun: one frame, three ticks (entry + two in RUN)
    step(0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 1, 16'h3050);
    urs = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 16'h0);
      urs += int'(ur);
    end
    step(1, 1, 0, 0, 16'h0);
    urs += int'(ur);
    check("underrun_pulses", urs, 2, 2);
    check("underrun_cnt", int'(cnt), 2, 2);

    // Disable mid-stream with a frame pending, then resume
    step(1, 1, 0, 1, 16'hC020);
    check("pending_loaded_ready", int'(ready), 0, 0);
    step(1, 0, 0, 0, 16'h0);
    check("disable_pdm", int'(pdm), 0, 0);
    check("disable_keeps_pending", int'(ready), 0, 0);
    step(1, 1, 1, 0, 16'h0);
    check("resume_promotes", int'(ready), 1, 1);

    // Counter saturation
    for (int i = 0; i < 20; i++) step(1, 1, 1, 0, 16'h0);
    check("cnt_saturates", int'(cnt), CMAX, CMAX);

    // Randomised stream (frame order and repeat checked by the scoreboard)
    step(0, 0, 0, 0, 16'h0);
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 24) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 1),
           16'($urandom));
    end
    // Back-to-back ticks with valid held: every tick either promotes or underruns
    for (int i = 0; i < 40; i++) step(1, 1, 1, 1, 16'($urandom));

    step(1, 1, 0, 0, 16'h0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
